// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, datapath mux selects, ALU op codes and trap causes.
package mc_ctrl_pkg;

   // FSM state encodings
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_UPPER    = 4'd8;
   localparam logic [3:0] S_ALUWB    = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JAL      = 4'd11;
   localparam logic [3:0] S_JALR     = 4'd12;
   localparam logic [3:0] S_JALR2    = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd14;

   // RV32I major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Immediate format select
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU operation
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_PASSB = 2'b11;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALURES  = 2'b10;

   // ALU operand selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States that own the memory bus and therefore wait on mem_ready
   function automatic logic is_mem_state(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/mc_control_unit_branch_resolve.sv
// Branch condition resolution from ALU subtract flags (a - b).
// carry = 1 means no borrow, i.e. a >= b unsigned.
module branch_resolve (
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       neg,
   input  logic       ovf,
   input  logic       carry,
   output logic       take,
   output logic       bad_funct3
);

   // Decode funct3 into the taken condition; 010/011 are not branches
   always_comb begin
      take       = 1'b0;
      bad_funct3 = 1'b0;
      case (funct3)
         3'b000:  take = zero;
         3'b001:  take = !zero;
         3'b100:  take = neg ^ ovf;
         3'b101:  take = !(neg ^ ovf);
         3'b110:  take = !carry;
         3'b111:  take = carry;
         default: bad_funct3 = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM driving a shared-ALU,
// single-memory datapath, with memory-wait timeout and illegal-opcode trap.
// Optional feature macro: MC_INSTRET_EN (retired-instruction counter).
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             neg,
   input  logic             ovf,
   input  logic             carry,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [2:0]       imm_src,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   logic [3:0] state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [1:0] cause_q, cause_d;
   logic       in_mem, timeout;
   logic       br_take, br_bad;

   branch_resolve u_branch (
      .funct3     (funct3),
      .zero       (zero),
      .neg        (neg),
      .ovf        (ovf),
      .carry      (carry),
      .take       (br_take),
      .bad_funct3 (br_bad)
   );

   // Wait counter is zero on entry to a memory state; the limit fires on the
   // cycle whose wait would make the count reach MEM_TIMEOUT, and only if
   // mem_ready is still low, so a late ready always wins.
   assign in_mem  = is_mem_state(state_q);
   assign timeout = in_mem && !mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));
   assign wait_d  = (in_mem && !mem_ready) ? wait_q + 8'd1 : 8'd0;

   // State, wait counter and sticky trap cause
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= 8'd0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   // Next-state and trap-cause selection
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_LUI, OP_AUIPC:  state_d = S_UPPER;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               default: begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (mem_ready)    state_d = S_MEMWB;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWRITE: begin
            if (mem_ready)    state_d = S_FETCH;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_EXECR, S_EXECI, S_UPPER: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH: begin
            if (br_bad) begin
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_JAL:     state_d = S_ALUWB;
         S_JALR:    state_d = S_JALR2;
         S_JALR2:   state_d = S_ALUWB;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_FETCH;
      endcase
   end

   // Datapath controls decoded from state; FETCH strobes are masked while
   // reset is held so a ready memory cannot load IR/PC during reset.
   always_comb begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALU_ADD;
      imm_src    = IMM_I;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            ir_write   = mem_ready && !reset;
            pc_write   = mem_ready && !reset;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
         end
         S_UPPER: begin
            imm_src   = IMM_U;
            alu_src_b = SRCB_IMM;
            if (op == OP_LUI) alu_op    = ALU_PASSB;
            else              alu_src_a = SRCA_OLDPC;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_SUB;
            pc_write  = br_take;
         end
         S_JAL, S_JALR2: begin
            pc_write  = 1'b1;
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
         end
         S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         default: ;
      endcase
   end

   assign trap       = (state_q == S_TRAP);
   assign trap_cause = cause_q;

`ifdef MC_INSTRET_EN
   logic [CNT_W-1:0] instret_q;

   // Count an instruction when the FSM returns to FETCH from elsewhere
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                         instret_q <= '0;
      else if (state_d == S_FETCH && state_q != S_FETCH) instret_q <= instret_q + 1'b1;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit. Each instruction is expanded by a
// reference model into its expected per-cycle control vectors (including
// memory waits, timeouts and traps), then replayed against the DUT.
module tb_mc_control_unit;

   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic          zero, neg, ovf, carry, mem_ready;
   logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op, trap_cause;
   logic [2:0]    imm_src;
   logic          trap;
   logic [CW-1:0] instret;

   always #5 clk = ~clk;

   mc_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3),
      .zero(zero), .neg(neg), .ovf(ovf), .carry(carry), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_src(imm_src), .trap(trap), .trap_cause(trap_cause),
      .instret(instret)
   );

   wire [19:0] obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                      result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap, trap_cause};

   typedef struct { bit rdy; logic [19:0] e; string tag; } cyc_t;
   cyc_t q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   retired = 0;

   localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTY = 7'b0110011,
                          ITY = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                          BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

   function automatic logic [19:0] mk(input bit mr, mw, ad, irw, pcw, rw,
                                      input logic [1:0] rs, a, b, aop,
                                      input logic [2:0] im);
      return {mr, mw, ad, irw, pcw, rw, rs, a, b, aop, im, 1'b0, 2'b00};
   endfunction

   function automatic logic [19:0] trapv(input logic [1:0] c);
      return {17'd0, 1'b1, c};
   endfunction

   function automatic logic [CW-1:0] exp_ir();
`ifdef MC_INSTRET_EN
      return CW'(retired);
`else
      return '0;
`endif
   endfunction

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", t, o, e);
      end
   endtask

   task automatic add(input bit r, input logic [19:0] e, input string t);
      q.push_back('{r, e, t});
   endtask

   // A memory phase of w wait cycles; w >= TO never completes and traps
   task automatic add_mem(input int w, input logic [19:0] wv, input logic [19:0] dv,
                          input string t, output bit trapped);
      int n;
      n = (w >= TO) ? TO : w;
      for (int i = 0; i < n; i++) add(1'b0, wv, t);
      trapped = (w >= TO);
      if (!trapped) add(1'b1, dv, t);
   endtask

   task automatic run(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input int wf, input int wm, output int ncyc);
      bit          tr, take;
      logic [1:0]  cause;
      logic [31:0] d;
      logic [19:0] FW, FD, DEC, WB, JV;
      FW  = mk(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
      FD  = mk(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
      DEC = mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010);
      WB  = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      JV  = mk(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000);
      q.delete();
      cause = 2'b10;
      d = a - b;
      op = o; funct3 = f;
      zero = (a == b); neg = d[31]; ovf = (a[31] ^ b[31]) & (a[31] ^ d[31]); carry = (a >= b);
      add_mem(wf, FW, FD, "fetch", tr);
      if (!tr) begin
         add(1'($urandom), DEC, "decode");
         case (o)
            RTY:   begin add(1'($urandom), mk(0,0,0,0,0,0,0,2,0,2,0), "execr"); add(1'($urandom), WB, "aluwb"); end
            ITY:   begin add(1'($urandom), mk(0,0,0,0,0,0,0,2,1,2,0), "execi"); add(1'($urandom), WB, "aluwb"); end
            LUI:   begin add(1'($urandom), mk(0,0,0,0,0,0,0,0,1,3,4), "lui");   add(1'($urandom), WB, "aluwb"); end
            AUIPC: begin add(1'($urandom), mk(0,0,0,0,0,0,0,1,1,0,4), "auipc"); add(1'($urandom), WB, "aluwb"); end
            LOAD: begin
               add(1'($urandom), mk(0,0,0,0,0,0,0,2,1,0,0), "memadr_l");
               add_mem(wm, mk(1,0,1,0,0,0,0,0,0,0,0), mk(1,0,1,0,0,0,0,0,0,0,0), "memread", tr);
               if (!tr) add(1'($urandom), mk(0,0,0,0,0,1,1,0,0,0,0), "memwb");
            end
            STORE: begin
               add(1'($urandom), mk(0,0,0,0,0,0,0,2,1,0,1), "memadr_s");
               add_mem(wm, mk(1,1,1,0,0,0,0,0,0,0,0), mk(1,1,1,0,0,0,0,0,0,0,0), "memwrite", tr);
            end
            BR: begin
               case (f)
                  3'd0:    take = (a == b);
                  3'd1:    take = (a != b);
                  3'd4:    take = ($signed(a) <  $signed(b));
                  3'd5:    take = ($signed(a) >= $signed(b));
                  3'd6:    take = (a <  b);
                  3'd7:    take = (a >= b);
                  default: begin take = 1'b0; tr = 1'b1; cause = 2'b01; end
               endcase
               add(1'($urandom), mk(0,0,0,0,take,0,0,2,0,1,0), "branch");
            end
            JAL:  begin add(1'($urandom), JV, "jal"); add(1'($urandom), WB, "aluwb"); end
            JALR: begin
               add(1'($urandom), mk(0,0,0,0,0,0,0,2,1,0,0), "jalr");
               add(1'($urandom), JV, "jalr2");
               add(1'($urandom), WB, "aluwb");
            end
            default: begin tr = 1'b1; cause = 2'b01; end
         endcase
      end
      if (tr) for (int i = 0; i < 3; i++) add(1'($urandom), trapv(cause), "trap_hold");
      else    retired++;
      foreach (q[i]) begin
         mem_ready = q[i].rdy;
         @(negedge clk);
         chk(q[i].tag, 32'(obs), 32'(q[i].e));
         @(posedge clk); #1;
      end
      ncyc = q.size();
      chk("instret", 32'(instret), 32'(exp_ir()));
   endtask

   task automatic do_reset();
      reset = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_out", 32'(obs), 32'(mk(1,0,0,0,0,0,2,0,2,0,0)));
      chk("rst_instret", 32'(instret), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      retired = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [6:0]  ops [9];
      logic [2:0]  bf  [6];
      logic [6:0]  o;
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [CW-1:0] wrap_exp;
      ops = '{LOAD, STORE, RTY, ITY, LUI, AUIPC, BR, JAL, JALR};
      bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      reset = 1'b1; op = RTY; funct3 = 3'd0;
      zero = 0; neg = 0; ovf = 0; carry = 0; mem_ready = 0;
      #1;
      do_reset();

      // Directed: R-type, branches, load with waits, others
      run(RTY, 3'd0, 32'd3, 32'd4, 0, 0, n);             chk("rtype_cycles", n, 4);
      run(BR, 3'd6, 32'd1, 32'd2, 0, 0, n);              chk("br_cycles", n, 3);
      run(BR, 3'd6, 32'd5, 32'd2, 0, 0, n);
      run(BR, 3'd4, 32'h8000_0000, 32'd1, 0, 0, n);
      run(BR, 3'd0, 32'd7, 32'd7, 0, 0, n);
      run(LOAD, 3'd2, 32'd0, 32'd0, 0, 3, n);            chk("load_wait_cycles", n, 8);
      run(STORE, 3'd2, 32'd0, 32'd0, 0, 0, n);           chk("store_cycles", n, 4);
      run(JAL, 3'd0, 32'd0, 32'd0, 2, 0, n);             chk("jal_cycles", n, 6);
      run(JALR, 3'd0, 32'd0, 32'd0, 0, 0, n);            chk("jalr_cycles", n, 5);
      run(LUI, 3'd0, 32'd0, 32'd0, 0, 0, n);
      run(AUIPC, 3'd0, 32'd0, 32'd0, 1, 0, n);
      run(ITY, 3'd0, 32'd0, 32'd0, 3, 0, n);
      run(STORE, 3'd0, 32'd0, 32'd0, 0, 3, n);

      // Randomized legal instruction stream, waits below the timeout
      for (int k = 0; k < 60; k++) begin
         o = ops[$urandom_range(0, 8)];
         f = (o == BR) ? bf[$urandom_range(0, 5)] : 3'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            default: b = $urandom;
         endcase
         run(o, f, a, b, $urandom_range(0, 3), $urandom_range(0, 3), n);
      end

      // Fetch timeout, then memread timeout
      run(RTY, 3'd0, 32'd0, 32'd0, 9, 0, n);
      do_reset();
      run(LOAD, 3'd0, 32'd0, 32'd0, 0, 9, n);
      do_reset();

      // Illegal opcode and bad branch funct3
      run(RTY, 3'd0, 32'd1, 32'd1, 0, 0, n);
      run(7'b0001111, 3'd0, 32'd0, 32'd0, 0, 0, n);
      do_reset();
      run(BR, 3'd2, 32'd0, 32'd0, 0, 0, n);
      do_reset();

      // Reset mid-instruction: abort in EXECR with a ready memory
      op = RTY; mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_execr", 32'(obs), 32'(mk(0,0,0,0,0,0,0,2,0,2,0)));
      #1 reset = 1'b1;
      #1;
      chk("abort_rst_out", 32'(obs), 32'(mk(1,0,0,0,0,0,2,0,2,0,0)));
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'b0; retired = 0;
      chk("abort_instret", 32'(instret), 32'd0);

      // Counter wrap: 17 ALU instructions on a 4-bit counter
      for (int k = 0; k < 17; k++) run(ITY, 3'($urandom), 32'd0, 32'd0, 0, 0, n);
`ifdef MC_INSTRET_EN
      wrap_exp = 4'd1;
`else
      wrap_exp = 4'd0;
`endif
      chk("instret_wrap17", 32'(instret), 32'(wrap_exp));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
